// File: rtl/uart_tx_sched_if.sv
// Purpose : bundles the requester byte streams, the UART TX load/busy pair and the status outputs of uart_tx_sched.
// Latency : none, wires only.
// Backpressure: REQ_READY (scheduler to requesters) and TX_BUSY (UART to scheduler) carry all flow control.
//
// Modports:
//   slave  - the scheduler: consumes REQ_*, TX_BUSY; drives REQ_READY, TX_P_DATA, TX_DATA_VALID, GRANT, ERR_TIMEOUT
//   master - the environment (requesters + UART TX): the mirror image of slave
interface uart_tx_sched_if #(
    parameter int N_REQ = 3,
    parameter int DW    = 8
);
    logic [N_REQ-1:0]    REQ_VALID;
    logic [N_REQ*DW-1:0] REQ_DATA;
    logic [N_REQ-1:0]    REQ_LAST;
    logic [N_REQ-1:0]    REQ_READY;
    logic                TX_BUSY;
    logic [DW-1:0]       TX_P_DATA;
    logic                TX_DATA_VALID;
    logic [N_REQ-1:0]    GRANT;
    logic                ERR_TIMEOUT;

    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_LAST, TX_BUSY,
        output REQ_READY, TX_P_DATA, TX_DATA_VALID, GRANT, ERR_TIMEOUT
    );

    modport master (
        output REQ_VALID, REQ_DATA, REQ_LAST, TX_BUSY,
        input  REQ_READY, TX_P_DATA, TX_DATA_VALID, GRANT, ERR_TIMEOUT
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Purpose : round-robin, packet-locked scheduler sharing one UART TX among N_REQ byte-stream requesters.
// Latency : request seen in IDLE at t -> GRANT and handshake at t+1 -> TX_DATA_VALID pulse at t+2.
// Backpressure: REQ_READY only for the granted requester, only in ISSUE and only while TX_BUSY is low.
//
// Ports:
//   CLK, RST           - clock, asynchronous active-low reset
//   bus (slave)        - REQ_VALID/REQ_DATA/REQ_LAST/REQ_READY per requester (byte i at [i*DW +: DW]),
//                        TX_BUSY in, TX_P_DATA/TX_DATA_VALID to the UART, GRANT (one-hot owner, 0 idle),
//                        ERR_TIMEOUT (one-cycle pulse when TX_BUSY never rose after a load)
module uart_tx_sched #(
    parameter int N_REQ   = 3,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             RST,
    uart_tx_sched_if.slave   bus
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    gidx_q,  gidx_d;     // binary index of the owner, mirrors grant_q
    logic [IW-1:0]    ptr_q,   ptr_d;      // round-robin search start
    logic [CW-1:0]    cnt_q,   cnt_d;      // cycles spent in WAIT_HI
    logic [DW-1:0]    pdata_q, pdata_d;
    logic             dv_q,    dv_d;
    logic             last_q,  last_d;
    logic             err_q,   err_d;

    // Next index after the current owner, wrapping at N_REQ (N_REQ need not be a power of two).
    function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
        inc_wrap = (v == IW'(N_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Arbiter: first valid requester at or after ptr_q, with wrap.
    // ------------------------------------------------------------------
    logic          arb_found;
    logic [IW-1:0] arb_idx;
    int            cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand     = (int'(ptr_q) + k) % N_REQ;
            cand_idx = IW'(cand);
            if (!arb_found && bus.REQ_VALID[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Owner's byte stream, selected by the registered grant index.
    // ------------------------------------------------------------------
    logic          sel_valid;
    logic          sel_last;
    logic [DW-1:0] sel_data;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gidx_q == IW'(i)) begin
                sel_valid = bus.REQ_VALID[i];
                sel_last  = bus.REQ_LAST[i];
                sel_data  = bus.REQ_DATA[i*DW +: DW];
            end
        end
    end

    // READY is combinational so a busy UART blocks the handshake in the same cycle.
    logic issue_open;
    logic hs;

    assign issue_open    = (state_q == S_ISSUE) && !bus.TX_BUSY;
    assign hs            = issue_open && sel_valid;
    assign bus.REQ_READY = issue_open ? grant_q : '0;

    // ------------------------------------------------------------------
    // Next-state and register-update logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        pdata_d = pdata_q;
        dv_d    = 1'b0;
        last_d  = last_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A UART still finishing a frame (e.g. after a reset) holds off arbitration.
                if (arb_found && !bus.TX_BUSY) begin
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                    gidx_d           = arb_idx;
                    state_d          = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // Owner may idle here indefinitely between bytes; the grant is not revoked.
                if (hs) begin
                    pdata_d = sel_data;
                    last_d  = sel_last;
                    dv_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT_HI;
                end
            end

            S_WAIT_HI: begin
                if (bus.TX_BUSY) begin
                    state_d = S_WAIT_LO;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // UART never acknowledged the load: drop the rest of the packet.
                    err_d   = 1'b1;
                    grant_d = '0;
                    ptr_d   = inc_wrap(gidx_q);
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_LO: begin
                if (!bus.TX_BUSY) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = inc_wrap(gidx_q);
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                gidx_d  = '0;
                ptr_d   = '0;
                cnt_d   = '0;
                pdata_d = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            pdata_q <= '0;
            dv_q    <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            pdata_q <= pdata_d;
            dv_q    <= dv_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign bus.GRANT         = grant_q;
    assign bus.TX_P_DATA     = pdata_q;
    assign bus.TX_DATA_VALID = dv_q;
    assign bus.ERR_TIMEOUT   = err_q;

endmodule
